jk_count_seq: RTL and testbench

JK_COUNT_SEQ -- requirements
Module: jk_count_seq

---
 rtl/jk_count_seq.sv | 133 +++++++++++++
 tb/tb_jk_count_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_count_seq.sv
// jk_count_seq: modulo up/down counter that drives an external JK flip-flop bank.
// Computes the next count value and issues registered J/K excitations that move the
// bank from the current count to the next one. The bank's Q outputs are fed back and
// checked against the expected bank value. A mismatch latches a sticky error and
// freezes the counter in FAULT until reset.
//
// Ports:
//   clk        rising-edge clock, shared with the JK bank
//   rst        synchronous active-high reset
//   en         count enable
//   up         direction (1 = up, 0 = down)
//   load_valid load request
//   load_data  value to load (clamped to MODULUS-1)
//   load_ready load accept, high only in RUN
//   q_fb       Q outputs fed back from the JK bank
//   j, k       registered J/K drive per bank bit
//   count      target count value
//   tc         terminal-count decode (RUN only)
//   err        sticky feedback-mismatch flag
module jk_count_seq #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             err
);

  typedef enum logic [1:0] {CLR, RUN, LOAD, FAULT} state_t;

  localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_r, count_nxt;
  logic [WIDTH-1:0] exp_r;
  logic [WIDTH-1:0] j_nxt, k_nxt;
  logic             err_nxt;
  logic             armed, armed_nxt;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] inc_val, dec_val;
  logic             mismatch;
  logic             accept;

  assign load_ready   = (state == RUN);
  assign accept       = load_valid & load_ready;
  assign load_clamped = ({1'b0, load_data} >= MOD_EXT) ? MAXV : load_data;
  assign inc_val      = (count_r == MAXV) ? '0 : count_r + WIDTH'(1);
  assign dec_val      = (count_r == '0) ? MAXV : count_r - WIDTH'(1);
  // armed stays low through the first RUN cycle: the bank has only just been cleared.
  assign mismatch     = armed & (q_fb != exp_r);

  assign count = count_r;
  assign tc    = (state == RUN) & (up ? (count_r == MAXV) : (count_r == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLR;
      count_r <= '0;
      exp_r   <= '0;
      j       <= '0;
      k       <= '1;
      err     <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state   <= state_nxt;
      count_r <= count_nxt;
      exp_r   <= count_r;
      j       <= j_nxt;
      k       <= k_nxt;
      err     <= err_nxt;
      armed   <= armed_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count_r;
    j_nxt     = '0;
    k_nxt     = '0;
    err_nxt   = err;
    armed_nxt = armed;
    target    = count_r;
    unique case (state)
      CLR: begin
        state_nxt = RUN;
        armed_nxt = 1'b0;
      end
      RUN: begin
        if (mismatch) begin
          state_nxt = FAULT;
          err_nxt   = 1'b1;
        end else begin
          armed_nxt = 1'b1;
          if (accept) begin
            target    = load_clamped;
            state_nxt = LOAD;
          end else if (en) begin
            target = up ? inc_val : dec_val;
          end
          count_nxt = target;
          // Bits rising get J, bits falling get K; unchanged bits stay 0/0.
          j_nxt = ~count_r & target;
          k_nxt = count_r & ~target;
        end
      end
      LOAD: begin
        if (mismatch) begin
          state_nxt = FAULT;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = RUN;
          armed_nxt = 1'b1;
        end
      end
      FAULT: begin
        err_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_jk_count_seq.sv
// Bench for jk_count_seq: ideal JK bank on q_fb (with optional stuck-at-0 mask),
// integer reference model, per-cycle compare plus literal expectations.
module tb_jk_count_seq;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_ready;
  logic [W-1:0] q_fb = '0;
  logic [W-1:0] j, k, count;
  logic         tc, err;
  logic [W-1:0] stuck = '0;

  jk_count_seq #(.WIDTH(W), .MODULUS(M)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .q_fb(q_fb), .j(j), .k(k), .count(count), .tc(tc), .err(err)
  );

  always #5 clk = ~clk;

  // Ideal JK bank: Q+ = J&~Q | ~K&Q, with a stuck-at-0 mask for fault injection.
  always @(posedge clk) q_fb <= ((j & ~q_fb) | (~k & q_fb)) & ~stuck;

  // Reference model
  typedef enum int {P_CLR, P_RUN, P_LOAD, P_FAULT} ph_t;
  ph_t ph = P_CLR;
  int  m_cnt = 0, m_exp = 0, m_j = 0, m_k = 0, m_err = 0;
  bit  m_armed = 1'b0;
  bit  checking = 1'b0;

  always @(posedge clk) begin
    int nxt;
    if (rst) begin
      ph = P_CLR; m_cnt = 0; m_exp = 0; m_j = 0; m_k = (1 << W) - 1;
      m_err = 0; m_armed = 1'b0; checking = 1'b1;
    end else begin
      case (ph)
        P_CLR: begin
          ph = P_RUN; m_j = 0; m_k = 0; m_armed = 1'b0; m_exp = m_cnt;
        end
        P_RUN, P_LOAD: begin
          if (m_armed && int'(q_fb) != m_exp) begin
            ph = P_FAULT; m_err = 1; m_j = 0; m_k = 0;
          end else if (ph == P_LOAD) begin
            ph = P_RUN; m_j = 0; m_k = 0; m_exp = m_cnt; m_armed = 1'b1;
          end else begin
            if (load_valid) begin
              nxt = (int'(load_data) >= M) ? M - 1 : int'(load_data);
              ph = P_LOAD;
            end else if (en) begin
              nxt = up ? (m_cnt + 1) % M : (m_cnt + M - 1) % M;
            end else begin
              nxt = m_cnt;
            end
            m_j = 0; m_k = 0;
            for (int b = 0; b < W; b++) begin
              if (((m_cnt >> b) & 1) == 0 && ((nxt >> b) & 1) == 1) m_j += (1 << b);
              if (((m_cnt >> b) & 1) == 1 && ((nxt >> b) & 1) == 0) m_k += (1 << b);
            end
            m_exp = m_cnt; m_cnt = nxt; m_armed = 1'b1;
          end
        end
        default: begin
          m_j = 0; m_k = 0;
        end
      endcase
    end
  end

  // Literal expectations posted by the stimulus process (-1 = don't care)
  bit    lit_on = 1'b0;
  string lit_name = "";
  int    l_c = -1, l_j = -1, l_k = -1, l_tc = -1, l_err = -1, l_lr = -1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int got, input int expv);
    vectors++;
    if (got != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Single compare process
  always @(negedge clk) begin
    if (checking) begin
      chk("count", int'(count), m_cnt);
      chk("j", int'(j), m_j);
      chk("k", int'(k), m_k);
      chk("err", int'(err), m_err);
      chk("load_ready", int'(load_ready), (ph == P_RUN) ? 1 : 0);
      chk("tc", int'(tc), ((ph == P_RUN) && (up ? (m_cnt == M - 1) : (m_cnt == 0))) ? 1 : 0);
      if (lit_on) begin
        if (l_c >= 0)   chk({lit_name, ".count"}, int'(count), l_c);
        if (l_j >= 0)   chk({lit_name, ".j"}, int'(j), l_j);
        if (l_k >= 0)   chk({lit_name, ".k"}, int'(k), l_k);
        if (l_tc >= 0)  chk({lit_name, ".tc"}, int'(tc), l_tc);
        if (l_err >= 0) chk({lit_name, ".err"}, int'(err), l_err);
        if (l_lr >= 0)  chk({lit_name, ".load_ready"}, int'(load_ready), l_lr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_lit(input string nm, input int c, input int jj, input int kk,
                            input int t, input int e, input int lr);
    lit_name = nm; l_c = c; l_j = jj; l_k = kk; l_tc = t; l_err = e; l_lr = lr;
    lit_on = 1'b1;
    @(negedge clk);
    #1;
    lit_on = 1'b0;
  endtask

  initial begin
    // Reset
    step();
    expect_lit("reset", 0, 0, 15, 0, 0, 0);
    step();
    rst = 1'b0;
    step();                       // CLR -> RUN
    en = 1'b1; up = 1'b1;
    expect_lit("clr_exit", 0, 0, 0, 0, 0, 1);

    // Count up through the wrap
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i % 10 == 0)
        expect_lit("wrap_up", 0, 0, 9, 0, 0, 1);
      else if (i % 10 == 9)
        expect_lit("tc_up", 9, -1, -1, 1, 0, 1);
      else
        expect_lit("up_seq", i % 10, -1, -1, 0, 0, 1);
    end

    // Down: 1 -> 0 -> 9
    up = 1'b0;
    step();
    expect_lit("tc_down", 0, -1, -1, 1, 0, 1);
    step();
    expect_lit("wrap_down", 9, 9, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step();
    expect_lit("down_to_3", 3, -1, -1, 0, 0, 1);

    // Load 7 from 3
    load_valid = 1'b1; load_data = 4'd7; up = 1'b1;
    step();
    load_valid = 1'b0;
    expect_lit("load7", 7, 4, 0, 0, 0, 0);
    step();
    expect_lit("load_exit", 7, 0, 0, 0, 0, 1);
    step();
    expect_lit("resume8", 8, 8, 7, 0, 0, 1);
    step();
    expect_lit("resume9", 9, 1, 0, 1, 0, 1);
    step();                       // 9 -> 0

    // Saturating load
    load_valid = 1'b1; load_data = 4'd12;
    step();
    load_valid = 1'b0;
    expect_lit("load12", 9, 9, 0, 0, 0, 0);
    step();

    // Reset during LOAD
    load_valid = 1'b1; load_data = 4'd2;
    step();
    load_valid = 1'b0; rst = 1'b1;
    expect_lit("load2", 2, 2, 9, 0, 0, 0);
    step();
    rst = 1'b0;
    expect_lit("rst_in_load", 0, 0, 15, 0, 0, 0);
    step();

    // Stuck-at-0 on bit 0 while counting up
    en = 1'b1; up = 1'b1;
    step();
    step();
    expect_lit("pre_fault", 2, -1, -1, 0, 0, 1);
    stuck = 4'b0001;
    step();
    expect_lit("fault_a", 3, -1, -1, 0, 0, 1);
    step();
    expect_lit("fault_b", 4, -1, -1, 0, 0, 1);
    step();
    expect_lit("fault_hit", 4, 0, 0, 0, 1, 0);
    step();
    expect_lit("fault_hold", 4, 0, 0, 0, 1, 0);
    stuck = '0; rst = 1'b1;
    step();
    rst = 1'b0;
    expect_lit("fault_reset", 0, 0, 15, 0, 0, 0);

    // Randomized run
    for (int i = 0; i < 600; i++) begin
      step();
      rst        = ($urandom_range(0, 63) == 0);
      en         = ($urandom_range(0, 3) != 0);
      up         = $urandom_range(0, 1) == 1;
      load_valid = ($urandom_range(0, 5) == 0);
      load_data  = W'($urandom_range(0, 15));
    end
    rst = 1'b0; load_valid = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
